digit_serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks through a registered carry. It trades latency for area: one CHUNK-wide ripple chain replaces a full WIDTH-wide chain. It sits in the adders library as the generalised, handshaked successor of the fixed-width combinational ripple adders, and serves as the arithmetic core for datapaths that accept multi-cycle results.

---
 rtl/adder_pkg.sv | 19 +
 rtl/full_adder_1bit.sv | 13 +
 rtl/ripple_adder_chunk.sv | 31 +++
 rtl/digit_serial_adder.sv | 139 +++++++++++++
 tb/tb_digit_serial_adder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder family.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int calc_chunks(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A counter needs at least one bit even when there is a single chunk.
   function automatic int cnt_width(input int n_chunks);
      return (n_chunks > 1) ? $clog2(n_chunks) : 1;
   endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell used to build the chunk ripple chain.
module full_adder_1bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);

   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/ripple_adder_chunk.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its MSB
// so the parent can form two's-complement overflow on the final chunk.
module ripple_adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_cin,
   output logic [CHUNK-1:0] o_sum,
   output logic             o_cout,
   output logic             o_c_msb
);

   logic [CHUNK:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar k = 0; k < CHUNK; k++) begin : g_fa
      full_adder_1bit u_fa (
         .i_a (i_a[k]),
         .i_b (i_b[k]),
         .i_c (w_c[k]),
         .o_s (o_sum[k]),
         .o_c (w_c[k+1])
      );
   end

   assign o_cout  = w_c[CHUNK];
   assign o_c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Handshaked adder/subtractor processing CHUNK bits per clock, LSB chunk first,
// with the inter-chunk carry held in a flop.
module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_carry_in,
   input  logic             i_sub,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry_out,
   output logic             o_overflow
);

   localparam int             N    = calc_chunks(WIDTH, CHUNK);
   localparam int             CW   = cnt_width(N);
   localparam logic [CW-1:0]  LAST = CW'(N - 1);

   if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_t            r_state;
   state_t            w_next;
   logic [CW-1:0]     r_cnt;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_sum;
   logic              r_carry;
   logic              r_cout;
   logic              r_ovf;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [CHUNK-1:0]  w_csum;
   logic              w_cout;
   logic              w_c_msb;
   logic [WIDTH-1:0]  w_top;
   logic              w_last;

   ripple_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .i_a     (r_a[CHUNK-1:0]),
      .i_b     (r_b[CHUNK-1:0]),
      .i_cin   (r_carry),
      .o_sum   (w_csum),
      .o_cout  (w_cout),
      .o_c_msb (w_c_msb)
   );

   // Operands shift down so the active chunk is always at bit 0; results enter at the top.
   assign w_top  = WIDTH'(w_csum) << (WIDTH - CHUNK);
   assign w_last = (r_cnt == LAST);

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_in_valid) w_next = BUSY;
            else            w_next = IDLE;
         end
         BUSY: begin
            if (w_last) w_next = DONE;
            else        w_next = BUSY;
         end
         DONE: begin
            if (i_out_ready) w_next = IDLE;
            else             w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   // State register with registered handshake outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_in_ready  <= (w_next == IDLE);
         r_out_valid <= (w_next == DONE);
      end
   end

   // Operand capture, per-chunk accumulation and final flag capture.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_in_valid) begin
                  r_a     <= i_a;
                  r_b     <= i_sub ? ~i_b : i_b;
                  r_carry <= i_sub ? ~i_carry_in : i_carry_in;
                  r_cnt   <= '0;
               end
            end
            BUSY: begin
               r_a     <= r_a >> CHUNK;
               r_b     <= r_b >> CHUNK;
               r_sum   <= (r_sum >> CHUNK) | w_top;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_cout <= w_cout;
                  r_ovf  <= w_c_msb ^ w_cout;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_sum       = r_sum;
   assign o_carry_out = r_cout;
   assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench: three adder instances (CHUNK = 4, 1, 16) driven with directed
// and random operations; a per-instance monitor checks results at each output handshake.
module tb_digit_serial_adder;

   localparam int W  = 16;
   localparam int NI = 3;

   typedef struct {
      logic [15:0] s;
      logic        co;
      logic        ov;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   done_cnt = 0;

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input int ch, input string nm, input logic [31:0] act,
                               input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL chunk%0d %s: got %0h, expected %0h", ch, nm, act, req);
      end
   endfunction

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
      exp_t m;
      int sa = int'($signed(a));
      int sb = int'($signed(b));
      int ua = int'(a);
      int ub = int'(b);
      int ci = cin ? 1 : 0;
      int sv;
      int uv;
      if (!sub) begin
         sv   = sa + sb + ci;
         uv   = ua + ub + ci;
         m.co = (uv >= 65536);
      end else begin
         sv   = sa - sb - ci;
         uv   = ua - ub - ci;
         m.co = (uv >= 0);
      end
      m.s   = 16'(uv);
      m.ov  = (sv > 32767) || (sv < -32768);
      m.acc = 0;
      return m;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int CH  = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
      localparam int NCH = W / CH;

      logic        rst_n = 1'b0;
      logic        in_valid = 1'b0;
      logic        in_ready;
      logic [15:0] a = 16'h0000;
      logic [15:0] b = 16'h0000;
      logic        ci = 1'b0;
      logic        sb = 1'b0;
      logic        out_valid;
      logic        out_ready = 1'b1;
      logic [15:0] sum;
      logic        co;
      logic        ov;
      exp_t        q[$];
      int          rdy_mode = 0;
      int          hold = 0;
      bit          pv = 1'b0;

      digit_serial_adder #(.WIDTH(W), .CHUNK(CH)) dut (
         .i_clk       (clk),
         .i_rst_n     (rst_n),
         .i_in_valid  (in_valid),
         .o_in_ready  (in_ready),
         .i_a         (a),
         .i_b         (b),
         .i_carry_in  (ci),
         .i_sub       (sb),
         .o_out_valid (out_valid),
         .i_out_ready (out_ready),
         .o_sum       (sum),
         .o_carry_out (co),
         .o_overflow  (ov)
      );

      // Consumer: ready driven shortly after each rising edge.
      initial forever begin
         @(posedge clk);
         #2;
         if (hold > 0 && out_valid) begin
            out_ready = 1'b0;
            hold--;
         end else if (rdy_mode == 1) begin
            out_ready = ($urandom_range(3) != 0);
         end else begin
            out_ready = 1'b1;
         end
      end

      // Monitor: latency on out_valid rise, result compare at handshake.
      initial forever begin
         exp_t e;
         @(negedge clk);
         if (out_valid && !pv) begin
            if (q.size() == 0) chk(CH, "unexpected_valid", 32'd1, 32'd0);
            else               chk(CH, "latency", 32'(cyc - q[0].acc), 32'(NCH));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk(CH, "unexpected_result", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk(CH, "sum", 32'(sum), 32'(e.s));
               chk(CH, "carry_out", 32'(co), 32'(e.co));
               chk(CH, "overflow", 32'(ov), 32'(e.ov));
            end
         end
         pv = out_valid;
      end

      task automatic wait_ready();
         int k = 0;
         while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
         end
         if (!in_ready) chk(CH, "ready_timeout", 32'(in_ready), 32'd1);
      endtask

      task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, input logic sv);
         exp_t e;
         wait_ready();
         a        = av;
         b        = bv;
         ci       = cv;
         sb       = sv;
         in_valid = 1'b1;
         e        = model(av, bv, cv, sv);
         e.acc    = cyc + 1;
         q.push_back(e);
         @(negedge clk);
         in_valid = 1'b0;
      endtask

      task automatic bp_op(input logic [15:0] av, input logic [15:0] bv);
         exp_t e;
         int   k = 0;
         e = model(av, bv, 1'b0, 1'b0);
         issue(av, bv, 1'b0, 1'b0);
         hold = 3;
         while (!(out_valid && out_ready) && k < 100) begin
            chk(CH, "bp_in_ready", 32'(in_ready), 32'd0);
            if (out_valid) chk(CH, "bp_sum_hold", 32'(sum), 32'(e.s));
            a        = 16'($urandom);
            in_valid = 1'($urandom_range(1));
            @(negedge clk);
            k++;
         end
         in_valid = 1'b0;
         chk(CH, "bp_handshake_seen", 32'(out_valid && out_ready), 32'd1);
         @(negedge clk);
         chk(CH, "post_hs_in_ready", 32'(in_ready), 32'd1);
         chk(CH, "post_hs_out_valid", 32'(out_valid), 32'd0);
      endtask

      // Stimulus sequence for this instance.
      initial begin
         int k = 0;
         repeat (2) @(negedge clk);
         chk(CH, "rst_in_ready", 32'(in_ready), 32'd1);
         chk(CH, "rst_out_valid", 32'(out_valid), 32'd0);
         chk(CH, "rst_sum", 32'(sum), 32'd0);
         chk(CH, "rst_flags", {30'd0, co, ov}, 32'd0);
         rst_n = 1'b1;
         @(negedge clk);

         issue(16'h1234, 16'h4321, 1'b0, 1'b0);
         issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
         issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
         issue(16'h0005, 16'h0007, 1'b0, 1'b1);
         issue(16'h8000, 16'h0001, 1'b0, 1'b1);
         issue(16'h0000, 16'h0000, 1'b1, 1'b1);
         bp_op(16'h0F0F, 16'h1234);

         issue(16'h1234, 16'h1111, 1'b0, 1'b0);
         repeat ((NCH >= 3) ? 2 : 0) @(negedge clk);
         rst_n = 1'b0;
         void'(q.pop_back());
         @(negedge clk);
         rst_n = 1'b1;
         chk(CH, "midrst_out_valid", 32'(out_valid), 32'd0);
         chk(CH, "midrst_in_ready", 32'(in_ready), 32'd1);
         chk(CH, "midrst_sum", 32'(sum), 32'd0);
         chk(CH, "midrst_flags", {30'd0, co, ov}, 32'd0);
         issue(16'h0001, 16'h0001, 1'b0, 1'b0);

         rdy_mode = 1;
         repeat (40) issue(16'($urandom), 16'($urandom), 1'($urandom_range(1)),
                           1'($urandom_range(1)));
         while (q.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
         end
         chk(CH, "drain", 32'(q.size()), 32'd0);
         rdy_mode = 0;
         done_cnt++;
      end
   end

   initial begin
      int k = 0;
      while (done_cnt < NI && k < 20000) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt < NI) begin
         n_checks++;
         n_fail++;
         $display("FAIL global_timeout: %0d of %0d instances finished", done_cnt, NI);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
